// File: rtl/core_byte_memory_bridge_if.sv
// Bus bundle between the rv32i core's word memory port, the bridge and the
// byte-wide synchronous memory. The bridge takes the slave view; the core and
// byte memory together take the master view.
interface core_byte_memory_bridge_if;
   logic [31:0] core_addr;
   logic [31:0] core_wr_data;
   logic        core_wr_ena;
   logic [31:0] core_rd_data;
   logic        core_ena;
   logic [31:0] byte_addr;
   logic [7:0]  byte_wr_data;
   logic        byte_wr_ena;
   logic [7:0]  byte_rd_data;

   modport slave (
      input  core_addr, core_wr_data, core_wr_ena, byte_rd_data,
      output core_rd_data, core_ena, byte_addr, byte_wr_data, byte_wr_ena
   );

   modport master (
      output core_addr, core_wr_data, core_wr_ena, byte_rd_data,
      input  core_rd_data, core_ena, byte_addr, byte_wr_data, byte_wr_ena
   );
endinterface

// File: rtl/core_byte_memory_bridge.sv
// Splits each 32-bit core access into four byte operations on a byte-wide
// memory with one-cycle read latency, stalling the core through core_ena.
// An optional one-word reuse register lets a repeated read of the last word
// complete without touching the byte memory.
module core_byte_memory_bridge #(
   parameter bit HIT_REUSE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   core_byte_memory_bridge_if.slave bus
);

   localparam logic [2:0] S_CAPTURE = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_RD_LAST = 3'd2;
   localparam logic [2:0] S_WR      = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   // control state (reset)
   logic [2:0]  r_state;
   logic [1:0]  r_k;
   logic        r_reuse_valid;
   logic [31:0] r_core_rd_data;
   logic        r_core_ena;
   logic [31:0] r_byte_addr;
   logic [7:0]  r_byte_wr_data;
   logic        r_byte_wr_ena;

   // datapath state (no reset)
   logic [29:0] r_base_hi;
   logic [31:0] r_wr_data;
   logic [23:0] r_lanes;
   logic [29:0] r_reuse_tag;
   logic [31:0] r_reuse_word;

   logic [1:0]  w_k_next;
   logic [31:0] w_next_addr;
   logic [31:0] w_rd_word;
   logic        w_hit;
   logic [7:0]  w_wr_byte;
   logic [1:0]  w_unused_addr_lsbs;

   // Low address bits are dropped silently: every access is word aligned.
   assign w_unused_addr_lsbs = bus.core_addr[1:0];

   // The byte index lives in the two low bits, so base+k never carries into
   // the upper address bits (0xFFFFFFFC stays within FC..FF).
   assign w_k_next    = r_k + 2'd1;
   assign w_next_addr = {r_base_hi, w_k_next};
   assign w_rd_word   = {bus.byte_rd_data, r_lanes};
   assign w_hit       = HIT_REUSE && r_reuse_valid &&
                        (bus.core_addr[31:2] == r_reuse_tag);

   // Select the next store byte for lane k+1.
   always_comb begin
      // NOTE: default assignment first so no path leaves w_wr_byte unassigned,
      // which would otherwise infer a latch.
      w_wr_byte = r_wr_data[7:0];
      case (w_k_next)
         2'd1:    w_wr_byte = r_wr_data[15:8];
         2'd2:    w_wr_byte = r_wr_data[23:16];
         2'd3:    w_wr_byte = r_wr_data[31:24];
         default: w_wr_byte = r_wr_data[7:0];
      endcase
   end

   // Sequencer: byte addressing, write strobes, core release and reuse valid.
   // NOTE: all state uses non-blocking assignments so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_CAPTURE;
         r_k            <= 2'd0;
         r_reuse_valid  <= 1'b0;
         r_core_rd_data <= 32'd0;
         r_core_ena     <= 1'b0;
         r_byte_addr    <= 32'd0;
         r_byte_wr_data <= 8'd0;
         r_byte_wr_ena  <= 1'b0;
      end else begin
         case (r_state)
            S_CAPTURE: begin
               r_core_ena    <= 1'b0;
               r_byte_wr_ena <= 1'b0;
               r_k           <= 2'd0;
               if (bus.core_wr_ena) begin
                  r_state        <= S_WR;
                  r_byte_addr    <= {bus.core_addr[31:2], 2'b00};
                  r_byte_wr_data <= bus.core_wr_data[7:0];
                  r_byte_wr_ena  <= 1'b1;
               end else if (w_hit) begin
                  r_state        <= S_RELEASE;
                  r_core_rd_data <= r_reuse_word;
                  r_core_ena     <= 1'b1;
               end else begin
                  r_state     <= S_RD;
                  r_byte_addr <= {bus.core_addr[31:2], 2'b00};
               end
            end
            S_RD: begin
               if (r_k != 2'd3) begin
                  r_byte_addr <= w_next_addr;
                  r_k         <= w_k_next;
               end else begin
                  r_state <= S_RD_LAST;
               end
            end
            S_RD_LAST: begin
               r_core_rd_data <= w_rd_word;
               r_core_ena     <= 1'b1;
               r_reuse_valid  <= 1'b1;
               r_state        <= S_RELEASE;
            end
            S_WR: begin
               if (r_k != 2'd3) begin
                  r_byte_addr    <= w_next_addr;
                  r_byte_wr_data <= w_wr_byte;
                  r_k            <= w_k_next;
               end else begin
                  r_byte_wr_ena  <= 1'b0;
                  r_core_rd_data <= r_wr_data;
                  r_core_ena     <= 1'b1;
                  r_reuse_valid  <= 1'b1;
                  r_state        <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               r_core_ena    <= 1'b0;
               r_byte_wr_ena <= 1'b0;
               r_k           <= 2'd0;
               r_state       <= S_CAPTURE;
            end
            default: begin
               r_state <= S_CAPTURE;
            end
         endcase
      end
   end

   // Word datapath: captured request, read lanes and the reuse word/tag.
   // NOTE: these registers carry no reset; every read of them is qualified by
   // the sequencer state or by r_reuse_valid, so their power-up value is never
   // observed.
   always_ff @(posedge clk) begin
      case (r_state)
         S_CAPTURE: begin
            r_base_hi <= bus.core_addr[31:2];
            r_wr_data <= bus.core_wr_data;
         end
         S_RD: begin
            case (r_k)
               2'd1:    r_lanes[7:0]   <= bus.byte_rd_data;
               2'd2:    r_lanes[15:8]  <= bus.byte_rd_data;
               2'd3:    r_lanes[23:16] <= bus.byte_rd_data;
               default: ;
            endcase
         end
         S_RD_LAST: begin
            r_reuse_word <= w_rd_word;
            r_reuse_tag  <= r_base_hi;
         end
         S_WR: begin
            if (r_k == 2'd3) begin
               r_reuse_word <= r_wr_data;
               r_reuse_tag  <= r_base_hi;
            end
         end
         default: ;
      endcase
   end

   assign bus.core_rd_data = r_core_rd_data;
   assign bus.core_ena     = r_core_ena;
   assign bus.byte_addr    = r_byte_addr;
   assign bus.byte_wr_data = r_byte_wr_data;
   assign bus.byte_wr_ena  = r_byte_wr_ena;

endmodule

// File: tb/tb_core_byte_memory_bridge.sv
// Directed bench for core_byte_memory_bridge: one instance with the reuse
// register (A) and one without (B), each behind a small byte-memory model.
module tb_core_byte_memory_bridge;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 clk = ~clk;

   core_byte_memory_bridge_if bus_a ();
   core_byte_memory_bridge_if bus_b ();

   core_byte_memory_bridge #(.HIT_REUSE(1'b1)) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   core_byte_memory_bridge #(.HIT_REUSE(1'b0)) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ena_cnt_a = 0;

   logic [7:0]  mem_a [256];
   logic [7:0]  mem_b [256];
   logic [31:0] sb_q [$];
   logic [31:0] tr_addr [21];
   logic        tr_we   [21];
   logic [7:0]  tr_wd   [21];

   function automatic logic [31:0] prog_word(input int i);
      case (i)
         0:       return 32'h0050_0093;  // addi x1, x0, 5
         1:       return 32'h0410_2023;  // sw   x1, 0x40(x0)
         default: return 32'h0400_2103;  // lw   x2, 0x40(x0)
      endcase
   endfunction

   // Byte memory A: one-cycle read latency, write on strobe; preloaded.
   initial begin
      for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
      mem_a[8'h10] = 8'h11;
      mem_a[8'h11] = 8'h22;
      mem_a[8'h12] = 8'h33;
      mem_a[8'h13] = 8'h44;
      for (int w = 0; w < 3; w++) begin
         logic [31:0] word;
         word = prog_word(w);
         for (int b = 0; b < 4; b++) mem_a[8'h80 + w * 4 + b] = word[b*8 +: 8];
      end
      bus_a.byte_rd_data <= 8'h00;
      forever begin
         @(posedge clk);
         bus_a.byte_rd_data <= mem_a[bus_a.byte_addr[7:0]];
         if (bus_a.byte_wr_ena) mem_a[bus_a.byte_addr[7:0]] = bus_a.byte_wr_data;
      end
   end

   // Byte memory B: same behaviour, starts empty.
   initial begin
      for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
      bus_b.byte_rd_data <= 8'h00;
      forever begin
         @(posedge clk);
         bus_b.byte_rd_data <= mem_b[bus_b.byte_addr[7:0]];
         if (bus_b.byte_wr_ena) mem_b[bus_b.byte_addr[7:0]] = bus_b.byte_wr_data;
      end
   end

   // Count completed-access pulses seen by core A.
   always @(posedge clk) begin
      if (bus_a.core_ena) ena_cnt_a <= ena_cnt_a + 1;
   end

   // Watchdog: the run must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic record(input bit sel, input int idx);
      tr_addr[idx] = sel ? bus_b.byte_addr    : bus_a.byte_addr;
      tr_we[idx]   = sel ? bus_b.byte_wr_ena  : bus_a.byte_wr_ena;
      tr_wd[idx]   = sel ? bus_b.byte_wr_data : bus_a.byte_wr_data;
   endtask

   // Called in a CAPTURE cycle (#1 after its edge); returns in the next
   // CAPTURE cycle. exp_cyc is the cycle index of the RELEASE pulse.
   task automatic run_access(input bit sel, input logic [31:0] addr, input bit we,
                             input logic [31:0] wdata, input logic [31:0] exp_word,
                             input int exp_cyc, input string tag,
                             output logic [31:0] rdata);
      int cyc;
      bit done;
      if (sel) begin
         bus_b.core_addr = addr; bus_b.core_wr_ena = we; bus_b.core_wr_data = wdata;
      end else begin
         bus_a.core_addr = addr; bus_a.core_wr_ena = we; bus_a.core_wr_data = wdata;
      end
      sb_q.push_back(exp_word);
      cyc = 0;
      done = 1'b0;
      record(sel, 0);
      while (!done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         record(sel, cyc);
         if (sel ? bus_b.core_ena : bus_a.core_ena) done = 1'b1;
      end
      check({tag, "_released"}, 64'(done), 64'd1);
      check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      rdata = sel ? bus_b.core_rd_data : bus_a.core_rd_data;
      check({tag, "_rd_data"}, 64'(rdata), 64'(sb_q.pop_front()));
      @(posedge clk);
      #1;
      check({tag, "_ena_drop"}, 64'(sel ? bus_b.core_ena : bus_a.core_ena), 64'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] xr [32];
      logic [31:0] pc, lb, ea, instr, stored;
      int cnt0;

      bus_a.core_addr = 32'h10; bus_a.core_wr_ena = 1'b0; bus_a.core_wr_data = 32'h0;
      bus_b.core_addr = 32'h20; bus_b.core_wr_ena = 1'b0; bus_b.core_wr_data = 32'h0;

      // Reset values.
      @(posedge clk);
      #1;
      check("rst_core_ena",     64'(bus_a.core_ena),     64'd0);
      check("rst_core_rd_data", 64'(bus_a.core_rd_data), 64'd0);
      check("rst_byte_addr",    64'(bus_a.byte_addr),    64'd0);
      check("rst_byte_wr_data", 64'(bus_a.byte_wr_data), 64'd0);
      check("rst_byte_wr_ena",  64'(bus_a.byte_wr_ena),  64'd0);
      rst_a = 1'b0;

      // Read miss of 0x10.
      run_access(1'b0, 32'h10, 1'b0, 32'h0, 32'h4433_2211, 6, "rd10_miss", rd);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rd10_addr%0d", i), 64'(tr_addr[i+1]), 64'(32'h10 + i));
         check($sformatf("rd10_we%0d", i), 64'(tr_we[i+1]), 64'd0);
      end

      // Read hit of 0x10: no new byte address.
      run_access(1'b0, 32'h10, 1'b0, 32'h0, 32'h4433_2211, 1, "rd10_hit", rd);
      check("rd10_hit_addr_held", 64'(tr_addr[1]), 64'h13);

      // Write 0xDEADBEEF to 0x20, then a hit read.
      run_access(1'b0, 32'h20, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, "wr20", rd);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] wd;
         wd = 32'hDEAD_BEEF;
         check($sformatf("wr20_addr%0d", i), 64'(tr_addr[i+1]), 64'(32'h20 + i));
         check($sformatf("wr20_we%0d", i), 64'(tr_we[i+1]), 64'd1);
         check($sformatf("wr20_wd%0d", i), 64'(tr_wd[i+1]), 64'(wd[i*8 +: 8]));
      end
      check("wr20_release_we", 64'(tr_we[5]), 64'd0);
      run_access(1'b0, 32'h20, 1'b0, 32'h0, 32'hDEAD_BEEF, 1, "rd20_hit", rd);

      // Misaligned read: 0x13 covers 0x10..0x13.
      run_access(1'b0, 32'h13, 1'b0, 32'h0, 32'h4433_2211, 6, "rd13_mis", rd);
      for (int i = 0; i < 4; i++)
         check($sformatf("rd13_addr%0d", i), 64'(tr_addr[i+1]), 64'(32'h10 + i));

      // Wrap: write at 0xFFFFFFFE covers FC..FF.
      run_access(1'b0, 32'hFFFF_FFFE, 1'b1, 32'h0102_0304, 32'h0102_0304, 5, "wrFC", rd);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wrFC_addr%0d", i), 64'(tr_addr[i+1]), 64'(32'hFFFF_FFFC + i));
         check($sformatf("wrFC_mem%0d", i), 64'(mem_a[8'hFC + i]), 64'(8'h04 - i));
      end

      // Reset in the middle of a write to 0x30 (primes reuse with 0x30 first).
      run_access(1'b0, 32'h30, 1'b0, 32'h0, 32'h0, 6, "rd30_pre", rd);
      bus_a.core_addr = 32'h30; bus_a.core_wr_ena = 1'b1; bus_a.core_wr_data = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      check("abort_c1_we",   64'(bus_a.byte_wr_ena), 64'd1);
      check("abort_c1_addr", 64'(bus_a.byte_addr),   64'h30);
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      #1;
      check("abort_core_ena",     64'(bus_a.core_ena),     64'd0);
      check("abort_core_rd_data", 64'(bus_a.core_rd_data), 64'd0);
      check("abort_byte_addr",    64'(bus_a.byte_addr),    64'd0);
      check("abort_byte_wr_data", 64'(bus_a.byte_wr_data), 64'd0);
      check("abort_byte_wr_ena",  64'(bus_a.byte_wr_ena),  64'd0);
      @(posedge clk);
      #1;
      check("abort_mem30", 64'(mem_a[8'h30]), 64'h0D);
      check("abort_mem32", 64'(mem_a[8'h32]), 64'h00);
      check("abort_mem33", 64'(mem_a[8'h33]), 64'h00);
      rst_a = 1'b0;
      run_access(1'b0, 32'h30, 1'b0, 32'h0, 32'h0000_000D, 6, "rd30_post", rd);

      // Core integration: tiny multicycle rv32i model (addi/sw/lw only).
      for (int i = 0; i < 32; i++) xr[i] = 32'h0;
      pc = 32'h80;
      lb = 32'h30;
      stored = 32'h0;
      cnt0 = ena_cnt_a;
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, pc, 1'b0, 32'h0, prog_word(i), (pc == lb) ? 1 : 6,
                    $sformatf("fetch%0d", i), instr);
         lb = pc;
         case (instr[6:0])
            7'h13: begin
               if (instr[11:7] != 5'd0)
                  xr[instr[11:7]] = xr[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};
            end
            7'h23: begin
               ea = xr[instr[19:15]] + {{20{instr[31]}}, instr[31:25], instr[11:7]};
               run_access(1'b0, ea, 1'b1, xr[instr[24:20]], xr[instr[24:20]], 5, "core_sw", rd);
               stored = xr[instr[24:20]];
               lb = {ea[31:2], 2'b00};
            end
            7'h03: begin
               ea = xr[instr[19:15]] + {{20{instr[31]}}, instr[31:20]};
               run_access(1'b0, ea, 1'b0, 32'h0, stored, ({ea[31:2], 2'b00} == lb) ? 1 : 6,
                          "core_lw", rd);
               if (instr[11:7] != 5'd0) xr[instr[11:7]] = rd;
               lb = {ea[31:2], 2'b00};
            end
            default: ;
         endcase
         pc = pc + 32'd4;
      end
      check("core_x2", 64'(xr[2]), 64'd5);
      check("core_ena_pulses", 64'(ena_cnt_a - cnt0), 64'd5);

      // HIT_REUSE=0: every read goes to memory.
      check("b_rst_core_ena", 64'(bus_b.core_ena), 64'd0);
      rst_b = 1'b0;
      run_access(1'b1, 32'h20, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, "b_wr20", rd);
      check("b_mem20", 64'({mem_b[8'h23], mem_b[8'h22], mem_b[8'h21], mem_b[8'h20]}),
            64'hDEAD_BEEF);
      run_access(1'b1, 32'h20, 1'b0, 32'h0, 32'hDEAD_BEEF, 6, "b_rd20", rd);
      run_access(1'b1, 32'h20, 1'b0, 32'h0, 32'hDEAD_BEEF, 6, "b_rd20_again", rd);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_byte_memory_bridge.md
# core_byte_memory_bridge

Bridges the multicycle rv32i core's 32-bit word memory port to a byte-wide synchronous memory with one-cycle read latency. Each core memory access is split into four sequential byte operations, and the core is stalled through its `ena` input until the word is complete. A one-word reuse register lets repeated reads of the same word skip the byte sequence. The block sits directly downstream of the core: core `mem_*` ports connect to `core_*`, and this block's `core_ena` drives the core's `ena`.

## Interface
- `HIT_REUSE`, default 1: 1 enables the one-word reuse register; 0 makes every access a full byte sequence.
- `clk` in 1: system clock; all flops on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `core_addr` in 32: core `mem_addr`. Bits [1:0] are ignored; base = {core_addr[31:2], 2'b00}.
- `core_wr_data` in 32: core `mem_wr_data`.
- `core_wr_ena` in 1: core `mem_wr_ena`; 1 = store word, 0 = load word.
- `core_rd_data` out 32: assembled word, little-endian; valid while `core_ena`=1.
- `core_ena` out 1: core clock enable; 1 for exactly one cycle per completed access.
- `byte_addr` out 32: byte memory address.
- `byte_wr_data` out 8: byte memory write data.
- `byte_wr_ena` out 1: byte memory write strobe.
- `byte_rd_data` in 8: byte at the `byte_addr` presented in the previous cycle.

## Operation
- All outputs are registered.
- Reset values: `core_ena`=0, `core_rd_data`=0, `byte_addr`=0, `byte_wr_data`=0, `byte_wr_ena`=0, state=CAPTURE, reuse valid=0, byte counter k=0.
- Byte order: byte k (k=0..3) at address base+k maps to word bits [8k+7:8k].
- **CAPTURE:** `core_ena`=0. Latch base, `core_wr_ena` and `core_wr_data`.
  - Write: go to WR.
  - Read with HIT_REUSE=1, reuse valid, and base equal to the reuse tag: go to RELEASE with `core_rd_data` = reuse word.
  - Any other read: go to RD.
- **RD:** issue `byte_addr`=base+k for k=0..3 on consecutive cycles. Each cycle after the first, latch `byte_rd_data` into lane k-1.
- **RD_LAST:** latch lane 3, then go to RELEASE. Load `core_rd_data` with the full word; reuse tag=base, reuse valid=1.
- **WR:** for k=0..3 on consecutive cycles, drive `byte_addr`=base+k, `byte_wr_data`=core_wr_data[8k+7:8k], `byte_wr_ena`=1. Then go to RELEASE.
  - `core_rd_data` = written word.
  - Reuse register updated to tag=base, word=written word, valid=1.
- **RELEASE:** `core_ena`=1 and `byte_wr_ena`=0 for exactly one cycle, then return to CAPTURE.
- `byte_wr_ena` is 0 in every state except WR.
- `byte_addr` holds its last value when not sequencing.
- Address wrap: base+k is computed modulo 2^32; base 0xFFFFFFFC accesses bytes FC..FF with no carry into other state.
- Misaligned `core_addr` is not flagged; low bits are silently dropped.
- Reset asserted mid-sequence aborts immediately and all outputs take their reset values. Bytes already written stay in memory; there is no rollback. Reuse valid is cleared.

## Timing
Cycle 0 is CAPTURE.
- **Read miss:**
  - Addresses base+0..3 appear in cycles 1-4.
  - Bytes 0..3 are sampled in cycles 2-5.
  - RELEASE (`core_ena`=1) is in cycle 6, so 7 cycles per access.
- **Read hit:** RELEASE in cycle 1; 2 cycles per access.
- **Write:** byte writes in cycles 1-4, RELEASE in cycle 5; 6 cycles per access.
- Back-to-back accesses: the next CAPTURE is the cycle after RELEASE. It samples the address the core updated on the RELEASE edge.
- After reset, the first access is always a miss.

## Test plan
- **Read miss:** memory bytes 0x10..0x13 = 11 22 33 44, `core_addr`=0x10, read.
  - `byte_addr` = 0x10, 0x11, 0x12, 0x13 in cycles 1-4.
  - `core_ena`=1 only in cycle 6, with `core_rd_data`=0x44332211.
- **Read hit:** repeat the read of 0x10 after the previous test.
  - `core_ena`=1 in cycle 1 with 0x44332211.
  - No `byte_addr` change.
- **Write then read:** write 0xDEADBEEF to 0x20.
  - `byte_wr_ena`=1 in cycles 1-4 with data EF, BE, AD, DE at 0x20..0x23.
  - `core_ena` in cycle 5.
  - A following read of 0x20 hits, returning 0xDEADBEEF in 2 cycles.
  - With HIT_REUSE=0, the same read takes 7 cycles and returns 0xDEADBEEF from memory.
- **Misaligned and wrap:** read `core_addr`=0x13 accesses 0x10..0x13. Write to 0xFFFFFFFE writes 0xFFFFFFFC..0xFFFFFFFF.
- **Reset mid-write:** assert `rst` during cycle 2 of a write to 0x30.
  - All outputs read 0 in the same cycle.
  - Only byte 0x30 (and possibly 0x31) has been modified.
  - The next read of 0x30 is a miss.
- **Core integration:** program `addi x1,x0,5` / `sw x1,0x40(x0)` / `lw x2,0x40(x0)`.
  - x2 = 5.
  - `core_ena` pulses exactly once per completed access.
